multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle processor. It sequences the shared datapath (ALU input muxes, memory, IR, register file, PC) through fetch, decode, execute, memory and writeback steps. Its outputs include the `ALUIn1Sel` select for the ALU first-operand mux. It decodes the 6-bit opcode in the IR, stalls on a memory-ready handshake, and flags unsupported opcodes.

## Interface
- `OPC_RTYPE`, 6'b000000, R-type opcode
- `OPC_LW`, 6'b100011, load word
- `OPC_SW`, 6'b101011, store word
- `OPC_BEQ`, 6'b000100, branch if equal
- `OPC_ADDI`, 6'b001000, add immediate
- `OPC_J`, 6'b000010, jump
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset; asynchronous and active-low
- `Op`  in  6  IR[31:26]
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  memory completes the current access this cycle
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemRead` / `MemWrite`  out  1  memory strobes
- `IRWrite`  out  1  instruction register load
- `RegDst`  out  1  write-register select: 0 = rt, 1 = rd
- `MemtoReg`  out  1  writeback select: 0 = ALUOut, 1 = MDR
- `RegWrite`  out  1  register file write
- `ALUIn1Sel`  out  1  ALU first operand: 0 = PC, 1 = A
- `ALUIn2Sel`  out  2  ALU second operand: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- `ALUOp`  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct field
- `PCSrc`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `PCEn`  out  1  PC load enable
- `State`  out  4  current state, for debug
- `IllegalOp`  out  1  sticky flag for an unsupported opcode

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Outputs not listed for a state are 0 in that state.
- FETCH:
  - IorD=0, MemRead=1, ALUIn1Sel=0, ALUIn2Sel=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCEn equal MemReady.
  - Stays in FETCH while MemReady=0; moves to DECODE when MemReady=1.
- DECODE:
  - ALUIn1Sel=0, ALUIn2Sel=11, ALUOp=00, which precomputes the branch target.
  - Next state by Op: LW/SW → MEMADR; RTYPE → EXEC; BEQ → BRANCH; ADDI → ADDIEX; J → JUMP.
  - Any other Op → FETCH, and IllegalOp is set.
- MEMADR: ALUIn1Sel=1, ALUIn2Sel=10, ALUOp=00. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: IorD=1, MemRead=1. Waits while MemReady=0, then goes to MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state FETCH.
- MEMWR: IorD=1, MemWrite=1. Waits while MemReady=0, then goes to FETCH.
- EXEC: ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state FETCH.
- BRANCH:
  - ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=01, PCSrc=01.
  - PCEn = Zero.
  - Next state FETCH.
- ADDIEX: ALUIn1Sel=1, ALUIn2Sel=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state FETCH.
- JUMP: PCSrc=10, PCEn=1. Next state FETCH.
- Op is sampled in DECODE and MEMADR only; the IR must not change outside FETCH.
- IllegalOp is sticky and is cleared only by reset.

## Timing
- Reset behaviour:
  - `rst_n` low forces State=FETCH and IllegalOp=0 immediately, without waiting for a clock edge.
  - While held in reset, outputs take the FETCH decode.
  - Reset asserted mid-instruction abandons the instruction; no RegWrite or MemWrite may be issued after reset asserts.
- Output timing:
  - All outputs are combinational from State.
  - The exceptions are IRWrite/PCEn in FETCH, which also depend on MemReady, and PCEn in BRANCH, which also depends on Zero.
- State register updates on the rising edge of `clk`.
- Cycle counts with MemReady held high:
  - R-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
  - ADDI: 4 cycles.
  - J: 3 cycles.
  - Illegal opcode: 2 cycles.
- Each cycle of MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes hold steady through the stall.
- MemWrite and RegWrite must never be high in the same cycle.
- PCEn must be high for at most one cycle per instruction outside BRANCH.

## Test plan
- Reset, MemReady=1, Op=RTYPE:
  - State sequence 0,1,6,7,0.
  - RegWrite=1 with RegDst=1 in cycle 4.
  - ALUIn1Sel: 0 in FETCH, 1 in EXEC.
- Op=LW with MemReady low for 2 cycles in MEMRD:
  - States 0,1,2,3,3,3,4,0.
  - MemRead and IorD=1 held during the stall.
  - MemtoReg=1, RegWrite=1 in MEMWB.
- Op=BEQ:
  - With Zero=1, PCEn=1 in BRANCH with PCSrc=01.
  - With Zero=0, PCEn=0.
  - Both cases return to FETCH after 3 cycles.
- Op=6'b111111:
  - DECODE goes to FETCH and IllegalOp=1, and the flag stays 1 across later valid instructions.
  - Asserting `rst_n`=0 clears IllegalOp.
- Op=SW with `rst_n` pulsed low mid-cycle during MEMWR:
  - State becomes 0 before the next edge.
  - MemWrite drops immediately.
  - The next instruction fetches normally.
- MemReady=0 for 3 cycles in FETCH:
  - IRWrite=0 and PCEn=0 for 3 cycles, then both are 1 for one cycle.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle processor datapath
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUIn1Sel,
    output logic [1:0] ALUIn2Sel,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] State,
    output logic       IllegalOp
);
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t state, next_state;
    logic   op_illegal;

    always_comb begin
        next_state = FETCH;
        op_illegal = 1'b0;
        case (state)
            FETCH:  next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OPC_LW, OPC_SW: next_state = MEMADR;
                    OPC_RTYPE:      next_state = EXEC;
                    OPC_BEQ:        next_state = BRANCH;
                    OPC_ADDI:       next_state = ADDIEX;
                    OPC_J:          next_state = JUMP;
                    default: begin
                        next_state = FETCH;
                        op_illegal = 1'b1;
                    end
                endcase
            end
            // Only LW/SW reach MEMADR, so anything but SW is treated as a load
            MEMADR: next_state = (Op == OPC_SW) ? MEMWR : MEMRD;
            MEMRD:  next_state = MemReady ? MEMWB : MEMRD;
            MEMWB:  next_state = FETCH;
            MEMWR:  next_state = MemReady ? FETCH : MEMWR;
            EXEC:   next_state = ALUWB;
            ALUWB:  next_state = FETCH;
            BRANCH: next_state = FETCH;
            ADDIEX: next_state = ADDIWB;
            ADDIWB: next_state = FETCH;
            JUMP:   next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            IllegalOp <= 1'b0;
        end else begin
            state <= next_state;
            if (op_illegal) begin
                IllegalOp <= 1'b1;
            end
        end
    end

    assign State = state;

    // Control decode is purely from state so reset takes effect without a clock edge
    always_comb begin
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUIn1Sel = 1'b0;
        ALUIn2Sel = 2'b00;
        ALUOp     = 2'b00;
        PCSrc     = 2'b00;
        PCEn      = 1'b0;
        case (state)
            FETCH: begin
                MemRead   = 1'b1;
                ALUIn2Sel = 2'b01;
                IRWrite   = MemReady;
                PCEn      = MemReady;
            end
            DECODE: begin
                ALUIn2Sel = 2'b11;
            end
            MEMADR, ADDIEX: begin
                ALUIn1Sel = 1'b1;
                ALUIn2Sel = 2'b10;
            end
            MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXEC: begin
                ALUIn1Sel = 1'b1;
                ALUOp     = 2'b10;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUIn1Sel = 1'b1;
                ALUOp     = 2'b01;
                PCSrc     = 2'b01;
                PCEn      = Zero;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: begin
                IorD = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control against an instruction-level model
module tb_multicycle_control;
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4, S_MEMWR = 5;
    localparam int S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       Zero, MemReady;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUIn1Sel;
    logic [1:0] ALUIn2Sel, ALUOp, PCSrc;
    logic       PCEn;
    logic [3:0] State;
    logic       IllegalOp;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUIn1Sel(ALUIn1Sel),
        .ALUIn2Sel(ALUIn2Sel), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
        .State(State), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [14:0] ctl;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    logic m_ill = 1'b0;

    // {IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUIn1Sel,ALUIn2Sel,ALUOp,PCSrc,PCEn}
    function automatic logic [14:0] exp_ctrl(input int s, input logic mr, input logic z);
        logic iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, a1 = 0, pcen = 0;
        logic [1:0] a2 = 2'b00, aop = 2'b00, pcs = 2'b00;
        case (s)
            S_FETCH:  begin mrd = 1; a2 = 2'b01; irw = mr; pcen = mr; end
            S_DECODE: a2 = 2'b11;
            S_MEMADR: begin a1 = 1; a2 = 2'b10; end
            S_MEMRD:  begin iord = 1; mrd = 1; end
            S_MEMWB:  begin m2r = 1; rw = 1; end
            S_MEMWR:  begin iord = 1; mwr = 1; end
            S_EXEC:   begin a1 = 1; aop = 2'b10; end
            S_ALUWB:  begin rdst = 1; rw = 1; end
            S_BRANCH: begin a1 = 1; aop = 2'b01; pcs = 2'b01; pcen = z; end
            S_ADDIEX: begin a1 = 1; a2 = 2'b10; end
            S_ADDIWB: rw = 1;
            S_JUMP:   begin pcs = 2'b10; pcen = 1; end
            default:  pcen = 0;
        endcase
        return {iord, mrd, mwr, irw, rdst, m2r, rw, a1, a2, aop, pcs, pcen};
    endfunction

    function automatic logic [14:0] dut_ctrl();
        return {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUIn1Sel,
                ALUIn2Sel, ALUOp, PCSrc, PCEn};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == OPC_RTYPE || op == OPC_LW || op == OPC_SW || op == OPC_BEQ ||
               op == OPC_ADDI || op == OPC_J;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", 32'(State), 32'(e.st));
                chk("ctrl", 32'(dut_ctrl()), 32'(e.ctl));
                chk("illegal", 32'(IllegalOp), 32'(e.ill));
                chk("wr_excl", 32'(MemWrite & RegWrite), 32'd0);
            end
        end
    end

    // One clock of stimulus with its expected response queued for the monitor
    task automatic cyc(input logic [5:0] op, input int st, input logic mr, input int zsel);
        exp_t e;
        @(posedge clk);
        #1;
        Op = op;
        MemReady = mr;
        Zero = (zsel == 2) ? 1'($urandom & 1) : 1'(zsel);
        e.st = 4'(st);
        e.ctl = exp_ctrl(st, mr, Zero);
        e.ill = m_ill;
        q.push_back(e);
    endtask

    task automatic check_reset_out();
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_illegal", 32'(IllegalOp), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(S_FETCH, MemReady, Zero)));
    endtask

    // Entered just after a rising edge; asserts reset mid-cycle and releases it one cycle later
    task automatic pulse_reset();
        exp_t e;
        #6;
        rst_n = 1'b0;
        #1;
        check_reset_out();
        @(posedge clk);
        #1;
        MemReady = 1'b0;
        m_ill = 1'b0;
        e.st = 4'(S_FETCH);
        e.ctl = exp_ctrl(S_FETCH, 1'b0, Zero);
        e.ill = 1'b0;
        q.push_back(e);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input int zsel, input bit abort);
        for (int i = 0; i < fs; i++) cyc(op, S_FETCH, 1'b0, zsel);
        cyc(op, S_FETCH, 1'b1, zsel);
        cyc(op, S_DECODE, 1'($urandom & 1), zsel);
        case (op)
            OPC_LW: begin
                cyc(op, S_MEMADR, 1'($urandom & 1), zsel);
                for (int i = 0; i < ms; i++) cyc(op, S_MEMRD, 1'b0, zsel);
                cyc(op, S_MEMRD, 1'b1, zsel);
                cyc(op, S_MEMWB, 1'($urandom & 1), zsel);
            end
            OPC_SW: begin
                cyc(op, S_MEMADR, 1'($urandom & 1), zsel);
                for (int i = 0; i < ms; i++) cyc(op, S_MEMWR, 1'b0, zsel);
                if (abort) begin
                    cyc(op, S_MEMWR, 1'b0, zsel);
                    pulse_reset();
                end else begin
                    cyc(op, S_MEMWR, 1'b1, zsel);
                end
            end
            OPC_RTYPE: begin
                cyc(op, S_EXEC, 1'($urandom & 1), zsel);
                cyc(op, S_ALUWB, 1'($urandom & 1), zsel);
            end
            OPC_BEQ:  cyc(op, S_BRANCH, 1'($urandom & 1), zsel);
            OPC_ADDI: begin
                cyc(op, S_ADDIEX, 1'($urandom & 1), zsel);
                cyc(op, S_ADDIWB, 1'($urandom & 1), zsel);
            end
            OPC_J:    cyc(op, S_JUMP, 1'($urandom & 1), zsel);
            default:  m_ill = 1'b1;
        endcase
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [5:0] opts [6];
        logic [5:0] op;
        opts[0] = OPC_RTYPE; opts[1] = OPC_LW; opts[2] = OPC_SW;
        opts[3] = OPC_BEQ;   opts[4] = OPC_ADDI; opts[5] = OPC_J;
        rst_n = 1'b0;
        Op = OPC_RTYPE;
        Zero = 1'b0;
        MemReady = 1'($urandom & 1);
        repeat (2) @(posedge clk);
        #1;
        check_reset_out();
        #6;
        pulse_reset();

        run_instr(OPC_RTYPE, 0, 0, 2, 1'b0);
        run_instr(OPC_LW, 0, 2, 2, 1'b0);
        run_instr(OPC_BEQ, 0, 0, 1, 1'b0);
        run_instr(OPC_BEQ, 0, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 2, 1'b0);
        run_instr(OPC_ADDI, 0, 0, 2, 1'b0);
        run_instr(OPC_J, 0, 0, 2, 1'b0);
        run_instr(OPC_SW, 0, 1, 2, 1'b1);
        run_instr(OPC_RTYPE, 3, 0, 2, 1'b0);
        run_instr(OPC_SW, 0, 0, 2, 1'b0);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 7) < 6) begin
                op = opts[$urandom_range(0, 5)];
            end else begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
            run_instr(op,
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
                      2,
                      (op == OPC_SW) && ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
